// File: rtl/gray_run_ctrl.sv
// Run controller for a 3-bit gray counter: issues exactly N enable cycles per run,
// honours pause/abort, and checks every counter step for a legal gray transition.
module gray_run_ctrl #(
  parameter int CNT_W  = 3,
  parameter int STEP_W = 8,
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [STEP_W-1:0] Steps,
  input  logic              Clear,
  input  logic              Pause,
  input  logic              Abort,
  input  logic [CNT_W-1:0]  CntOut,
  input  logic              CntOverflow,
  output logic              CntEn,
  output logic              CntRst,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic              Err,
  output logic [WRAP_W-1:0] WrapCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Gray code of the counter's maximum binary value: a single leading one.
  localparam logic [CNT_W-1:0] GRAY_MAX = {1'b1, {(CNT_W-1){1'b0}}};

  state_t              state;
  logic [STEP_W-1:0]   remaining;
  logic                chk_pending;
  logic [CNT_W-1:0]    prev;
  logic                err;
  logic                aborted;
  logic [WRAP_W-1:0]   wrap_count;
  logic [CNT_W-1:0]    expected_next;
  logic                unused_inputs;

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign expected_next = bin2gray(gray2bin(prev) + CNT_W'(1));

  // Abort gates the counter in the very cycle it is raised, not one cycle later.
  assign CntEn     = (state == S_RUN) && !Pause && !Abort;
  assign CntRst    = (state == S_CLEAR) && !Abort;
  assign Busy      = (state != S_IDLE);
  assign Done      = (state == S_DONE) && !Abort;
  assign Aborted   = aborted;
  assign Err       = err;
  assign WrapCount = wrap_count;

  // Overflow is informational only; wraps are detected from the gray codes themselves.
  assign unused_inputs = CntOverflow;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      remaining   <= '0;
      chk_pending <= 1'b0;
      prev        <= '0;
      err         <= 1'b0;
      wrap_count  <= '0;
      aborted     <= 1'b0;
    end else begin
      aborted     <= 1'b0;
      chk_pending <= CntEn;

      // The counter output lags its enable by one cycle, so each step is judged a cycle later.
      if (chk_pending) begin
        if (CntOut != expected_next) begin
          err <= 1'b1;
        end
        if (prev == GRAY_MAX && CntOut == '0 && wrap_count != '1) begin
          wrap_count <= wrap_count + WRAP_W'(1);
        end
      end

      if (CntEn) begin
        prev      <= CntOut;
        remaining <= remaining - STEP_W'(1);
      end

      if (state != S_IDLE && Abort) begin
        state   <= S_IDLE;
        aborted <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (Start) begin
              remaining  <= Steps;
              err        <= 1'b0;
              wrap_count <= '0;
              if (Steps == '0) begin
                state <= S_DONE;
              end else if (Clear) begin
                state <= S_CLEAR;
              end else begin
                state <= S_RUN;
              end
            end
          end
          S_CLEAR: state <= S_RUN;
          S_RUN: begin
            if (CntEn && remaining == STEP_W'(1)) begin
              state <= S_DRAIN;
            end
          end
          S_DRAIN: state <= S_DONE;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Bench for gray_run_ctrl: scripted run table, fault-injected counter, random runs checked
// against a run-level arithmetic model, and an asynchronous mid-run reset.
module tb_gray_run_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Steps = 8'd0;
  logic       Clear = 1'b0;
  logic       Pause = 1'b0;
  logic       Abort = 1'b0;
  logic [2:0] CntOut;
  logic       CntOverflow;
  logic       CntEn;
  logic       CntRst;
  logic       Busy;
  logic       Done;
  logic       Aborted;
  logic       Err;
  logic [3:0] WrapCount;

  int checks = 0;
  int errors = 0;

  gray_run_ctrl #(.CNT_W(3), .STEP_W(8), .WRAP_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Steps(Steps), .Clear(Clear),
    .Pause(Pause), .Abort(Abort), .CntOut(CntOut), .CntOverflow(CntOverflow),
    .CntEn(CntEn), .CntRst(CntRst), .Busy(Busy), .Done(Done), .Aborted(Aborted),
    .Err(Err), .WrapCount(WrapCount)
  );

  always #5 Clk = ~Clk;

  // External gray counter, optionally faulty: with skip_en it jumps binary 2 -> 4 (011 -> 110).
  logic [2:0] cnt_bin = 3'd0;
  logic       skip_en = 1'b0;
  always @(posedge Clk) begin
    if (CntRst) cnt_bin <= 3'd0;
    else if (CntEn) cnt_bin <= (skip_en && cnt_bin == 3'd2) ? 3'd4 : cnt_bin + 3'd1;
  end
  assign CntOut      = cnt_bin ^ (cnt_bin >> 1);
  assign CntOverflow = CntEn && (cnt_bin == 3'd7);

  logic       en_obs [0:511];
  logic [2:0] out_obs[0:511];
  logic       err_obs[0:511];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gray3(input int p);
    logic [2:0] b;
    b = p[2:0];
    return b ^ (b >> 1);
  endfunction

  // Drives one run cycle by cycle; pause/abort are placed by step count, not by DUT state.
  task automatic run_txn(input int steps, input bit clr, input int pause_at, input int pause_len,
                         input int abort_at, input int pct,
                         output int n_en, output int busy_len, output int done_cyc, output int n_done,
                         output bit got_abort, output int n_pause, output logic err_d,
                         output logic err_f, output logic [3:0] wrap_f, output logic [2:0] out_f);
    int  ph = 0;
    bit  abort_used = 0;
    bit  prev_end = 0;
    bit  prev_abort = 0;
    bit  fin = 0;
    bit  sched_pause;
    int  clr_cyc;
    n_en = 0; busy_len = 0; done_cyc = -1; n_done = 0; got_abort = 0; n_pause = 0;
    err_d = 1'bx;
    clr_cyc = (clr && steps > 0) ? 1 : 0;
    @(negedge Clk);
    Start = 1'b1; Steps = steps[7:0]; Clear = clr; Pause = 1'b0; Abort = 1'b0;
    for (int t = 1; t <= 400 && !fin; t++) begin
      @(negedge Clk);
      Start = (pct > 0 && !prev_end && $urandom_range(0, 9) == 0);
      Steps = 8'($urandom);
      Clear = 1'($urandom);
      Abort = (abort_at >= 0 && !abort_used && n_en == abort_at);
      if (Abort) abort_used = 1;
      sched_pause = (n_en == pause_at && ph < pause_len);
      if (sched_pause) ph++;
      Pause = sched_pause || (pct > 0 && $urandom_range(0, 99) < pct);
      if (Pause && !Abort && t > clr_cyc && n_en < steps) n_pause++;
      #1;
      en_obs[t] = CntEn; out_obs[t] = CntOut; err_obs[t] = Err;
      if (Pause || Abort) check("en_gated", CntEn, 0);
      check("cnt_rst", CntRst, (clr && steps > 0 && t == 1 && !Abort));
      check("aborted_pulse", Aborted, prev_abort);
      if (Aborted) got_abort = 1;
      if (CntEn) n_en++;
      if (Done) begin n_done++; done_cyc = t; err_d = Err; end
      if (Busy) busy_len++;
      else fin = 1;
      prev_end = Done || Abort;
      prev_abort = Abort;
    end
    if (!fin) check("run_timeout", 0, 1);
    err_f = Err; wrap_f = WrapCount; out_f = CntOut;
    Start = 1'b0; Pause = 1'b0; Abort = 1'b0;
    $display("run steps=%0d clr=%0d en=%0d busy=%0d done_at=%0d aborted=%0d err=%0d wraps=%0d out=%b",
             steps, clr, n_en, busy_len, done_cyc, got_abort, err_f, wrap_f, out_f);
  endtask

  typedef struct {
    int         steps;
    bit         clr;
    int         pause_at;
    int         pause_len;
    int         abort_at;
    int         exp_en;
    int         exp_busy;
    int         exp_done;
    bit         exp_abort;
    int         exp_wrap;
    logic [2:0] exp_out;
  } vec_t;

  vec_t tbl[8];

  int n_en, busy_len, done_cyc, n_done, n_pause;
  bit got_abort;
  logic err_d, err_f;
  logic [3:0] wrap_f;
  logic [2:0] out_f;
  int pos;

  initial begin
    logic [2:0] seq1[8];
    seq1 = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    //          steps clr pa  pl  ab   en  busy done ab wrap out
    tbl[0] = '{8,   1, -1, 0, -1,  8,  11,  11, 0, 1,  3'b000};
    tbl[1] = '{20,  1, -1, 0, -1,  20, 23,  23, 0, 2,  3'b110};
    tbl[2] = '{5,   0,  2, 3, -1,  5,  10,  10, 0, 1,  3'b001};
    tbl[3] = '{10,  1, -1, 0,  4,  4,  6,   -1, 1, 0,  3'b110};
    tbl[4] = '{0,   0, -1, 0, -1,  0,  1,   1,  0, 0,  3'b110};
    tbl[5] = '{1,   0, -1, 0, -1,  1,  3,   3,  0, 0,  3'b111};
    tbl[6] = '{6,   1,  2, 2,  2,  2,  4,   -1, 1, 0,  3'b011};
    tbl[7] = '{130, 1, -1, 0, -1,  130, 133, 133, 0, 15, 3'b011};

    #3;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_cnten", CntEn, 0);
    check("rst_cntrst", CntRst, 0);
    check("rst_aborted", Aborted, 0);
    check("rst_err", Err, 0);
    check("rst_wrap", WrapCount, 0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].steps, tbl[i].clr, tbl[i].pause_at, tbl[i].pause_len, tbl[i].abort_at, 0,
              n_en, busy_len, done_cyc, n_done, got_abort, n_pause, err_d, err_f, wrap_f, out_f);
      check("tbl_en", n_en, tbl[i].exp_en);
      check("tbl_busy", busy_len, tbl[i].exp_busy);
      check("tbl_done_cyc", done_cyc, tbl[i].exp_done);
      check("tbl_n_done", n_done, (tbl[i].exp_done >= 0) ? 1 : 0);
      check("tbl_aborted", got_abort, tbl[i].exp_abort);
      check("tbl_wrap", wrap_f, tbl[i].exp_wrap);
      check("tbl_err", err_f, 0);
      check("tbl_out", out_f, tbl[i].exp_out);
      if (i == 0) begin
        for (int t = 1; t <= 11; t++) check("seq_en", en_obs[t], (t >= 2 && t <= 9));
        for (int k = 0; k < 8; k++) check("seq_out", out_obs[k+3], seq1[k]);
      end
    end
    pos = 2;

    // Faulty counter skips a code: Err must rise and stay up through Done.
    skip_en = 1'b1;
    run_txn(8, 1, -1, 0, -1, 0, n_en, busy_len, done_cyc, n_done, got_abort, n_pause,
            err_d, err_f, wrap_f, out_f);
    skip_en = 1'b0;
    check("fault_en", n_en, 8);
    check("fault_done_cyc", done_cyc, 11);
    check("fault_err_at_done", err_d, 1);
    check("fault_err_after", err_f, 1);
    pos = 1;

    run_txn(3, 0, -1, 0, -1, 0, n_en, busy_len, done_cyc, n_done, got_abort, n_pause,
            err_d, err_f, wrap_f, out_f);
    check("err_cleared_by_start", err_obs[1], 0);
    check("err_clean_run", err_f, 0);
    check("clean_out", out_f, gray3(4));
    pos = 4;

    for (int r = 0; r < 40; r++) begin
      int  steps, abort_at, start_pos, exp_en;
      bit  clr, cleared;
      steps = $urandom_range(0, 30);
      clr = 1'($urandom);
      abort_at = (steps > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, steps) : -1;
      run_txn(steps, clr, -1, 0, abort_at, 20, n_en, busy_len, done_cyc, n_done, got_abort,
              n_pause, err_d, err_f, wrap_f, out_f);
      cleared = clr && steps > 0 && abort_at != 0;
      start_pos = cleared ? 0 : pos;
      exp_en = (abort_at >= 0) ? abort_at : steps;
      check("rnd_en", n_en, exp_en);
      check("rnd_aborted", got_abort, abort_at >= 0);
      check("rnd_n_done", n_done, (abort_at >= 0) ? 0 : 1);
      if (abort_at < 0) begin
        check("rnd_busy", busy_len, (steps == 0) ? 1 : (cleared ? 1 : 0) + steps + n_pause + 2);
        check("rnd_done_cyc", done_cyc, busy_len);
      end
      check("rnd_wrap", wrap_f, ((start_pos + exp_en) / 8 > 15) ? 15 : (start_pos + exp_en) / 8);
      check("rnd_err", err_f, 0);
      pos = (start_pos + exp_en) % 8;
      check("rnd_out", out_f, gray3(pos));
    end

    // Asynchronous reset in the middle of a run.
    @(negedge Clk);
    Start = 1'b1; Steps = 8'd20; Clear = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check("pre_reset_busy", Busy, 1);
    check("pre_reset_en", CntEn, 1);
    #1;
    Reset = 1'b1;
    #1;
    check("arst_busy", Busy, 0);
    check("arst_cnten", CntEn, 0);
    check("arst_cntrst", CntRst, 0);
    check("arst_done", Done, 0);
    check("arst_aborted", Aborted, 0);
    check("arst_err", Err, 0);
    check("arst_wrap", WrapCount, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    #1;
    check("post_reset_idle", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
